// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port asynchronous SRAM controller with a valid/ready
// request port and a one-cycle response pulse.
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (accepted on valid && ready)
//   req_write                      1 = write, 0 = read
//   req_addr, req_wdata, req_be    word address, write data, byte enables (bit0 = low byte)
//   rsp_valid, rsp_rdata           completion pulse and read data
//   sram_dq                        bidirectional SRAM data bus
//   sram_addr, sram_*_n            SRAM address and active-low controls, all flop-driven
module sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_WAIT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  inout  wire  [DATA_WIDTH-1:0] sram_dq,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_lb_n,
  output logic                  sram_ub_n
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BE_W  = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BE_W-1:0]       r_be;
  logic                  r_write;

  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic                  r_lb_n;
  logic                  r_ub_n;
  logic                  r_dq_oe;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_accept;
  logic                  w_rd_done;
  logic                  w_rsp_nxt;
  logic                  w_write_nxt;
  logic [BE_W-1:0]       w_be_nxt;
  logic                  w_ce_n_nxt;
  logic                  w_oe_n_nxt;
  logic                  w_we_n_nxt;
  logic                  w_lb_n_nxt;
  logic                  w_ub_n_nxt;
  logic                  w_dq_oe_nxt;

  // Next-state, wait counter and next pin values (pins are decoded from the
  // next state so that every SRAM pin comes straight off a flop).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_rd_done   = 1'b0;
    w_rsp_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (req_write) begin
            w_state_nxt = WR_SETUP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = READ;
            w_cnt_nxt   = CNT_W'(RD_WAIT);
          end
        end
      end
      READ: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_rd_done   = 1'b1;
          w_rsp_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      WR_SETUP: begin
        w_state_nxt = WR_PULSE;
        w_cnt_nxt   = CNT_W'(WR_WAIT);
      end
      WR_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      WR_HOLD: begin
        w_state_nxt = IDLE;
        w_rsp_nxt   = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_write_nxt = w_accept ? req_write : r_write;
    w_be_nxt    = w_accept ? req_be    : r_be;

    w_ce_n_nxt  = (w_state_nxt == IDLE);
    w_oe_n_nxt  = (w_state_nxt != READ);
    w_we_n_nxt  = (w_state_nxt != WR_PULSE);
    w_dq_oe_nxt = (w_state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD});

    // Reads always enable both lanes; writes follow the captured byte enables.
    if (w_state_nxt == IDLE) begin
      w_lb_n_nxt = 1'b1;
      w_ub_n_nxt = 1'b1;
    end else if (w_write_nxt) begin
      w_lb_n_nxt = ~w_be_nxt[0];
      w_ub_n_nxt = ~w_be_nxt[1];
    end else begin
      w_lb_n_nxt = 1'b0;
      w_ub_n_nxt = 1'b0;
    end
  end

  // State, captured request and pin registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_write     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_write <= req_write;
      end
      r_ce_n      <= w_ce_n_nxt;
      r_oe_n      <= w_oe_n_nxt;
      r_we_n      <= w_we_n_nxt;
      r_lb_n      <= w_lb_n_nxt;
      r_ub_n      <= w_ub_n_nxt;
      r_dq_oe     <= w_dq_oe_nxt;
      r_rsp_valid <= w_rsp_nxt;
      // Sampled on the edge that ends the last READ cycle.
      if (w_rd_done) begin
        r_rdata <= sram_dq;
      end
    end
  end

  // Ready drops immediately with reset so no request slips in while held.
  assign req_ready = (r_state == IDLE) && !reset;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign sram_addr = r_addr;
  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;
  assign sram_lb_n = r_lb_n;
  assign sram_ub_n = r_ub_n;
  assign sram_dq   = r_dq_oe ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, SRAM data width; fixed at 16 (two byte lanes).
REQ-003 SHALL have parameter RD_WAIT, default 1, range 0..15; extra read-strobe cycles.
REQ-004 SHALL have parameter WR_WAIT, default 1, range 0..15; extra write-pulse cycles.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-006 SHALL have the following request ports: req_valid  in  1  request present; req_ready  out  1  controller can accept; req_write  in  1  1=write, 0=read; req_addr  in  ADDR_WIDTH  word address; req_wdata  in  16  write data; req_be  in  2  byte enables, bit0 = low byte, bit1 = high byte.
REQ-007 SHALL have the following response ports: rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  16  read data.
REQ-008 SHALL have the following SRAM pins: sram_dq  inout  16  data bus; sram_addr  out  ADDR_WIDTH  address; sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low controls.

Function
REQ-009 SHALL use FSM states IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-010 SHALL assert req_ready only in IDLE with reset low; a request is accepted on a rising edge with req_valid && req_ready.
REQ-011 SHALL register addr, wdata, be and write on acceptance; request inputs are ignored until the next acceptance.
REQ-012 SHALL drive all SRAM outputs from flops: no combinational paths from request inputs to pins.
REQ-013 SHALL, on an accepted read: IDLE->READ for RD_WAIT+1 cycles with ce_n=0, oe_n=0, we_n=1, lb_n=ub_n=0, and DQ released.
REQ-014 SHALL sample sram_dq into rsp_rdata on the edge ending the last READ cycle; state->IDLE.
REQ-015 SHALL, on an accepted write: WR_SETUP for 1 cycle (ce_n=0, we_n=1, oe_n=1, DQ driven).
REQ-016 SHALL continue the write with WR_PULSE for WR_WAIT+1 cycles (we_n=0), then WR_HOLD for 1 cycle (we_n=1, ce_n=0, DQ still driven), then IDLE.
REQ-017 SHALL, during a write, set lb_n=~be[0] and ub_n=~be[1] from WR_SETUP through WR_HOLD; be=00 still runs the full cycle with both lanes disabled.
REQ-018 SHALL hold sram_addr and driven DQ stable from WR_SETUP through WR_HOLD; oe_n=1 whenever DQ is driven, never overlapping with oe_n=0.
REQ-019 SHALL pulse rsp_valid high for exactly one cycle: the first IDLE cycle after READ or WR_HOLD.
REQ-020 SHALL leave rsp_rdata unchanged on write completion.
REQ-021 SHALL allow a new request to be accepted in the same cycle rsp_valid is high (back-to-back, no idle bubble).
REQ-022 SHALL give read latency as acceptance edge to rsp_valid of RD_WAIT+2 cycles.
REQ-023 SHALL give write latency as acceptance edge to rsp_valid of WR_WAIT+4 cycles.
REQ-024 SHALL use a wait counter 4 bits wide, loaded on state entry and counting down to 0; it does not wrap.
REQ-025 SHALL keep sram_addr at its last value in IDLE, with ce_n=oe_n=we_n=lb_n=ub_n=1 and DQ released.

Reset
REQ-026 SHALL, while reset is high at an edge: state=IDLE, ce_n=oe_n=we_n=lb_n=ub_n=1, DQ=z, rsp_valid=0, rsp_rdata=0, sram_addr=0, counter=0.
REQ-027 SHALL hold req_ready=0 while reset is high.
REQ-028 SHALL, on reset mid-operation, abandon the operation at the next edge with no rsp_valid; an interrupted write may leave SRAM partially written.
REQ-029 SHALL set req_ready=1 in the first cycle after reset deasserts.

Verification
REQ-030 SHALL cover reset: reset held 3 cycles -> all control pins 1, DQ=z, rsp_valid=0, req_ready=0; release -> req_ready=1 next cycle.
REQ-031 SHALL cover write then read (RD_WAIT=1, WR_WAIT=1): write 0xA55A @0x012 be=11, then read @0x012 -> rsp_rdata=0xA55A; read rsp_valid 3 cycles after acceptance, write rsp_valid 5 cycles after.
REQ-032 SHALL cover a byte write: write 0x1234 be=01 @0x012 (holding 0xA55A) -> read returns 0xA534; be=10 with 0x1234 -> 0x125A.
REQ-033 SHALL cover back-to-back reads: req_valid held for reads @0x001, @0x002 -> second accepted in the first rsp_valid cycle; responses exactly 3 cycles apart.
REQ-034 SHALL cover write timing (WR_WAIT=3): we_n low exactly 4 cycles; addr/DQ stable and ce_n=0 one cycle before and after we_n low; oe_n=1 throughout.
REQ-035 SHALL cover reset during WR_PULSE: next edge we_n=ce_n=1, DQ=z, no rsp_valid; after release req_ready=1 and a new read completes normally.
